// File: rtl/fp_pkg.sv
// Shared encodings and IEEE-754 constant helpers for the sequential FP multiplier.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM,
    ST_DONE
  } state_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Magnitude helpers return the word without its sign bit, zero-extended to 64.
  function automatic logic [63:0] fp_inf_mag(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] fp_max_mag(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_qnan_mag(input int exp_w, input int man_w);
    return fp_inf_mag(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mul_shift_add.sv
// Iterative unsigned multiplier: one load cycle, then one multiplier bit per cycle.
module fp_mul_shift_add #(
  parameter int M = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [M-1:0]   i_a,
  input  logic [M-1:0]   i_b,
  output logic           o_done,
  output logic [2*M-1:0] o_product
);
  localparam int CNT_W = $clog2(M + 1);

  logic [M-1:0]     r_mcand;
  logic [2*M-1:0]   r_prod;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [M:0]       w_sum;

  // Upper half accumulates; the multiplier sits in the lower half and shifts out.
  assign w_sum     = {1'b0, r_prod[2*M-1:M]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign o_done    = r_busy && (r_cnt == CNT_W'(M - 1));
  assign o_product = r_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_mcand <= i_a;
      r_prod  <= {{M{1'b0}}, i_b};
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_prod <= {w_sum, r_prod[M-1:1]};
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754-style multiplier: shift-add mantissa core followed by a single
// normalise/round/special-case cycle, with valid/ready handshakes on both sides.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [1:0]           round_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid,
  output logic                 inexact
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;
  localparam int PW  = 2 * M;
  localparam int EW2 = EXP_W + 2;

  localparam logic signed [EW2-1:0] BIAS = EW2'(fp_bias(EXP_W));
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EONE = EW2'(1);
  localparam logic [W-2:0] INF_MAG  = (W-1)'(fp_inf_mag(EXP_W, MAN_W));
  localparam logic [W-2:0] MAX_MAG  = (W-1)'(fp_max_mag(EXP_W, MAN_W));
  localparam logic [W-2:0] QNAN_MAG = (W-1)'(fp_qnan_mag(EXP_W, MAN_W));

  state_e r_state, w_state_nxt;
  logic [W-1:0] r_a, r_b, r_result;
  rmode_e       r_rm;
  logic         r_start;
  logic         r_ovf, r_unf, r_inv, r_inx;
  logic         w_accept, w_done;
  logic [PW-1:0] w_prod;

  logic             w_sa, w_sb, w_sign;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [M-1:0]     w_ma, w_mb;

  logic                  w_msb, w_guard, w_sticky, w_inc, w_carry;
  logic [MAN_W-1:0]      w_frac;
  logic [MAN_W:0]        w_frac_r;
  logic signed [EW2-1:0] w_exp_pre, w_exp_r;

  logic [W-1:0] w_res;
  logic         w_ovf, w_unf, w_inv, w_inx;

  assign {w_sa, w_ea, w_fa} = r_a;
  assign {w_sb, w_eb, w_fb} = r_b;
  assign w_sign   = w_sa ^ w_sb;
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  // Subnormals feed a zero mantissa so they behave exactly like signed zero.
  assign w_ma     = w_a_zero ? '0 : {1'b1, w_fa};
  assign w_mb     = w_b_zero ? '0 : {1'b1, w_fb};

  fp_mul_shift_add #(
    .M(M)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (r_start),
    .i_a      (w_ma),
    .i_b      (w_mb),
    .o_done   (w_done),
    .o_product(w_prod)
  );

  assign w_msb     = w_prod[PW-1];
  assign w_frac    = w_msb ? w_prod[PW-2:M]  : w_prod[PW-3:M-1];
  assign w_guard   = w_msb ? w_prod[M-1]     : w_prod[M-2];
  assign w_sticky  = w_msb ? |w_prod[M-2:0]  : |w_prod[M-3:0];
  assign w_exp_pre = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS
                   + $signed({{(EW2-1){1'b0}}, w_msb});

  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      RM_RNE:  w_inc = w_guard & (w_sticky | w_frac[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = ~w_sign & (w_guard | w_sticky);
      RM_RDN:  w_inc = w_sign & (w_guard | w_sticky);
      default: w_inc = 1'b0;
    endcase
  end

  // A carry out of the fraction leaves it all-zero; only the exponent moves.
  assign w_frac_r = {1'b0, w_frac} + (MAN_W+1)'(w_inc);
  assign w_carry  = w_frac_r[MAN_W];
  assign w_exp_r  = w_exp_pre + $signed({{(EW2-1){1'b0}}, w_carry});

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    w_inx = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_inf) || (w_b_zero && w_a_inf)) begin
      w_res = {1'b0, QNAN_MAG};
      w_inv = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_res = {w_sign, INF_MAG};
    end else if (w_a_zero || w_b_zero) begin
      w_res = {w_sign, {(W-1){1'b0}}};
    end else if (w_exp_r < EONE) begin
      w_res = {w_sign, {(W-1){1'b0}}};
      w_unf = 1'b1;
      w_inx = 1'b1;
    end else if (w_exp_r >= EMAX) begin
      w_ovf = 1'b1;
      w_inx = 1'b1;
      case (r_rm)
        RM_RNE:  w_res = {w_sign, INF_MAG};
        RM_RTZ:  w_res = {w_sign, MAX_MAG};
        RM_RUP:  w_res = w_sign ? {1'b1, MAX_MAG} : {1'b0, INF_MAG};
        RM_RDN:  w_res = w_sign ? {1'b1, INF_MAG} : {1'b0, MAX_MAG};
        default: w_res = {w_sign, INF_MAG};
      endcase
    end else begin
      w_res = {w_sign, w_exp_r[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
      w_inx = w_guard | w_sticky;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_MUL;
      end
      ST_MUL: begin
        if (w_done) w_state_nxt = ST_NORM;
      end
      ST_NORM: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_rm     <= RM_RNE;
      r_start  <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inv    <= 1'b0;
      r_inx    <= 1'b0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_a  <= a;
        r_b  <= b;
        r_rm <= rmode_e'(round_mode);
      end
      if (r_state == ST_NORM) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
        r_inv    <= w_inv;
        r_inx    <= w_inx;
      end
    end
  end

  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign invalid   = r_inv;
  assign inexact   = r_inx;

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1, operands and mode valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands.
REQ-007 SHALL have ports a and b, input, W each, IEEE-754-style operands.
REQ-008 SHALL have port round_mode, input, 2, with encoding 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port result, output, W, product.
REQ-012 SHALL have ports overflow, underflow, invalid and inexact, output, 1 each, flags qualified by out_valid.

Function
REQ-013 SHALL implement FSM IDLE -> MUL -> NORM -> DONE -> IDLE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; a transfer occurs on in_valid && in_ready; a, b and round_mode are captured at that transfer.
REQ-015 MUL SHALL run exactly MAN_W+1 cycles, one multiplier bit per cycle (shift-add), with a counter of width clog2(MAN_W+2) and a 2*(MAN_W+1)-bit product.
REQ-016 NORM SHALL take 1 cycle to normalise, round and resolve special cases, then enter DONE.
REQ-017 out_valid SHALL be high exactly in DONE and SHALL rise MAN_W+3 cycles after the accept edge (26 for defaults); latency SHALL be fixed, special operands included.
REQ-018 In DONE, result and flags SHALL be held stable while out_ready = 0; on out_ready = 1 the FSM SHALL go to IDLE; no new operand is accepted in the same cycle.
REQ-019 Sign SHALL be sign(a) XOR sign(b) for every non-NaN result, zeros included.
REQ-020 Exponent SHALL be computed signed, EXP_W+2 bits, as ea+eb-bias, bias = 2^(EXP_W-1)-1, +1 when the product MSB is set.
REQ-021 Rounding SHALL use guard and sticky bits (sticky = OR of all lower product bits); a mantissa carry-out on rounding SHALL increment the exponent.
REQ-022 Subnormal inputs (exp 0, fraction != 0) SHALL be treated as zero of the same sign.
REQ-023 A result exponent <= 0 after rounding SHALL flush to signed zero, setting underflow and inexact.
REQ-024 A result exponent >= all-ones SHALL set overflow and inexact; the result SHALL be inf for RNE; max finite for RTZ; +inf or -max for mode 10; -inf or +max for mode 11.
REQ-025 NaN * any, or 0 * inf, SHALL give canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0) with invalid=1 and other flags 0.
REQ-026 inf * finite-nonzero SHALL give signed inf; 0 * finite SHALL give signed zero; no flags set in either case.
REQ-027 inexact SHALL be set when guard or sticky is nonzero.

Reset
REQ-028 rst_n low SHALL force, asynchronously: state IDLE, in_ready 1, out_valid 0, result 0, all flags 0, counter 0.
REQ-029 Reset during MUL, NORM or DONE SHALL abort the operation; no result is emitted after release.

Structure
REQ-030 Shared package fp_pkg SHALL hold the round-mode encodings, the FSM state enum and bias/qNaN/inf constant functions of EXP_W and MAN_W.
REQ-031 The iterative mantissa multiplier SHALL be sub-module fp_mul_shift_add (start, done, operands, product); the FSM, rounding and special cases SHALL stay in fp_mul_seq.

Verification
REQ-032 0x3F800000 * 0x3FC00000, RNE -> 0x3FC00000, all flags 0, out_valid exactly 26 cycles after accept.
REQ-033 0x3F800001 * 0x3F800001: RNE -> 0x3F800002 with inexact=1; mode 10 -> 0x3F800003; RTZ -> 0x3F800002.
REQ-034 0x7F000000 * 0x40000000: RNE -> 0x7F800000 with overflow=1 and inexact=1; RTZ -> 0x7F7FFFFF.
REQ-035 0x00800000 * 0x3F000000 -> 0x00000000 with underflow=1; 0x00000000 * 0x7F800000 -> 0x7FC00000 with invalid=1.
REQ-036 out_ready held 0 for 5 cycles in DONE -> result stable and in_ready 0; rst_n pulsed mid-MUL -> out_valid 0 and in_ready 1 immediately, no result emitted.
